// File: rtl/requant_activation.sv
// Three-stage requantizer: scales wide accumulators, rounds and shifts them, then applies
// the zero point, the activation mode and the output clamp. Every beat carries its own config snapshot.
module requant_activation #(
    parameter int LANES   = 4,
    parameter int IN_W    = 32,
    parameter int OUT_W   = 8,
    parameter int MULT_W  = 16,
    parameter int SHIFT_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_we,
    input  logic [MULT_W-1:0]        cfg_mult,
    input  logic [SHIFT_W-1:0]       cfg_shift,
    input  logic [OUT_W-1:0]         cfg_zp,
    input  logic [OUT_W-1:0]         cfg_cap,
    input  logic [1:0]               cfg_mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*IN_W-1:0]    in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*OUT_W-1:0]   out_data,
    output logic [LANES-1:0]         out_sat,
    output logic                     busy
);
    localparam int P = IN_W + MULT_W + 1;

    logic [MULT_W-1:0]  mult_q;
    logic [SHIFT_W-1:0] shift_q;
    logic [OUT_W-1:0]   zp_q, cap_q;
    logic [1:0]         mode_q;

    logic               v1, v2, v3;
    logic [P-1:0]       p1 [LANES];
    logic [P-1:0]       r2 [LANES];
    logic [SHIFT_W-1:0] shift1;
    logic [OUT_W-1:0]   zp1, cap1, zp2, cap2;
    logic [1:0]         mode1, mode2;
    logic               en;

    function automatic logic [P-1:0] scale(input logic [IN_W-1:0] a, input logic [MULT_W-1:0] m);
        logic signed [P-1:0] a_ext, m_ext, prod;
        a_ext = {{(P-IN_W){a[IN_W-1]}}, a};
        m_ext = {{(P-MULT_W){1'b0}}, m};
        prod  = a_ext * m_ext;
        return prod;
    endfunction

    // Adding half an LSB before the arithmetic shift rounds ties toward +infinity.
    function automatic logic [P-1:0] round_shift(input logic [P-1:0] p, input logic [SHIFT_W-1:0] sh);
        logic signed [P-1:0] one, bias, sum, res;
        one  = {{(P-1){1'b0}}, 1'b1};
        bias = '0;
        if (sh != '0)
            bias = one << (sh - SHIFT_W'(1));
        sum = $signed(p) + bias;
        res = sum >>> sh;
        return res;
    endfunction

    // Returns {sat, value}. Only the upper bound and the NONE-mode floor count as saturation.
    function automatic logic [OUT_W:0] activate(input logic [P-1:0] r, input logic [OUT_W-1:0] zp,
                                                input logic [OUT_W-1:0] cap, input logic [1:0] mode);
        logic signed [P:0] v, r_s, zp_s, cap_s, hi, lo, max_s, min_s;
        logic              lo_sat;
        logic [OUT_W:0]    res;
        r_s    = {r[P-1], r};
        zp_s   = {{(P+1-OUT_W){zp[OUT_W-1]}}, zp};
        cap_s  = {{(P+1-OUT_W){cap[OUT_W-1]}}, cap};
        max_s  = {{(P-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
        min_s  = {{(P-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
        v      = r_s + zp_s;
        hi     = max_s;
        lo     = min_s;
        lo_sat = 1'b1;
        case (mode)
            2'd1: begin lo = zp_s; lo_sat = 1'b0; end
            2'd2: begin lo = zp_s; hi = cap_s; lo_sat = 1'b0; end
            default: ;
        endcase
        if (mode == 2'd2 && cap_s < zp_s)
            res = {1'b0, zp};
        else if (v > hi)
            res = {1'b1, hi[OUT_W-1:0]};
        else if (v < lo)
            res = {lo_sat, lo[OUT_W-1:0]};
        else
            res = {1'b0, v[OUT_W-1:0]};
        return res;
    endfunction

    assign en        = !v3 || out_ready;
    assign in_ready  = en;
    assign out_valid = v3;
    assign busy      = v1 || v2 || v3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_q  <= MULT_W'(1);
            shift_q <= '0;
            zp_q    <= '0;
            cap_q   <= {1'b0, {(OUT_W-1){1'b1}}};
            mode_q  <= '0;
        end else if (cfg_we) begin
            mult_q  <= cfg_mult;
            shift_q <= cfg_shift;
            zp_q    <= cfg_zp;
            cap_q   <= cfg_cap;
            mode_q  <= cfg_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            shift1   <= '0;
            zp1      <= '0;
            cap1     <= '0;
            mode1    <= '0;
            zp2      <= '0;
            cap2     <= '0;
            mode2    <= '0;
            out_data <= '0;
            out_sat  <= '0;
            for (int k = 0; k < LANES; k++) begin
                p1[k] <= '0;
                r2[k] <= '0;
            end
        end else if (en) begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
            if (in_valid) begin
                for (int k = 0; k < LANES; k++)
                    p1[k] <= scale(in_data[k*IN_W +: IN_W], mult_q);
                shift1 <= shift_q;
                zp1    <= zp_q;
                cap1   <= cap_q;
                mode1  <= mode_q;
            end
            if (v1) begin
                for (int k = 0; k < LANES; k++)
                    r2[k] <= round_shift(p1[k], shift1);
                zp2   <= zp1;
                cap2  <= cap1;
                mode2 <= mode1;
            end
            if (v2) begin
                for (int k = 0; k < LANES; k++)
                    {out_sat[k], out_data[k*OUT_W +: OUT_W]} <= activate(r2[k], zp2, cap2, mode2);
            end
        end
    end
endmodule

// File: tb/tb_requant_activation.sv
// Scoreboard bench for requant_activation: directed beats push hand-computed results,
// an independent monitor pops and compares whenever an output beat transfers.
module tb_requant_activation;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cfg_we = 1'b0;
    logic [15:0] cfg_mult = 16'd1;
    logic [4:0]  cfg_shift = '0;
    logic [7:0]  cfg_zp = '0;
    logic [7:0]  cfg_cap = 8'd127;
    logic [1:0]  cfg_mode = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [127:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_sat;
    logic        busy;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  sat;
        bit          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          acc_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          bp_on = 1'b0;
    bit          held = 1'b0;
    logic [31:0] held_data;
    logic [3:0]  held_sat;

    requant_activation dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
        .cfg_zp(cfg_zp), .cfg_cap(cfg_cap), .cfg_mode(cfg_mode), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (bp_on) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            held = 1'b0;
        end else begin
            if (in_valid && in_ready) acc_q.push_back(cyc);
            if (out_valid && out_ready) begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {32'd0, out_data}, 64'hdead_beef_dead_beef);
                end else begin
                    e = exp_q.pop_front();
                    a = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
                    chk("out_data", {32'd0, out_data}, {32'd0, e.data});
                    chk("out_sat", {60'd0, out_sat}, {60'd0, e.sat});
                    if (e.lat) chk("latency", 64'(cyc - a), 64'd3);
                end
            end else if (out_valid) begin
                if (held) begin
                    chk("stall_data", {32'd0, out_data}, {32'd0, held_data});
                    chk("stall_sat", {60'd0, out_sat}, {60'd0, held_sat});
                end
                held = 1'b1;
                held_data = out_data;
                held_sat = out_sat;
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic cfg(input int m, input int sh, input int zp, input int cap, input int mode);
        cfg_mult = m[15:0];
        cfg_shift = sh[4:0];
        cfg_zp = zp[7:0];
        cfg_cap = cap[7:0];
        cfg_mode = mode[1:0];
        cfg_we = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic send(input int a0, input int a1, input int a2, input int a3,
                        input int e0, input int e1, input int e2, input int e3,
                        input logic [3:0] s, input bit lat, input bit push);
        bit   ok;
        exp_t e;
        ok = 1'b0;
        in_data = {a3[31:0], a2[31:0], a1[31:0], a0[31:0]};
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        else if (push) begin
            e.data = {e3[7:0], e2[7:0], e1[7:0], e0[7:0]};
            e.sat = s;
            e.lat = lat;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk(nm, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_out_sat", {60'd0, out_sat}, 64'd0);
        rst_n = 1'b1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Rounding, saturation and shift-by-one with a scale factor.
        cfg(1, 3, 0, 127, 0);
        send(1000, 1004, -1004, 4,   125, 126, -125, 1,    4'b0000, 1, 1);
        send(12, -12, 2000, -2000,   2, -1, 127, -128,     4'b1100, 1, 1);
        cfg(3, 1, 0, 127, 0);
        send(5, -5, 0, 100,          8, -7, 0, 127,        4'b1000, 1, 1);
        cfg(65535, 16, 0, 127, 0);
        send(100, -100, 1, -1,       100, -100, 1, -1,     4'b0000, 1, 1);
        drain("drain_round");

        // Activation modes with zp=-5.
        cfg(1, 0, -5, 127, 1);
        send(-40, 20, 200, -1000,    -5, 15, 127, -5,      4'b0100, 1, 1);
        cfg(1, 0, -5, 6, 2);
        send(20, -40, 8, 11,         6, -5, 3, 6,          4'b0001, 1, 1);
        cfg(1, 0, -5, 6, 3);
        send(-40, 200, -200, 20,     -45, 127, -128, 15,   4'b0110, 1, 1);
        cfg(1, 0, -5, 6, 0);
        send(-40, 200, -200, 20,     -45, 127, -128, 15,   4'b0110, 1, 1);
        cfg(1, 0, 10, 3, 2);
        send(0, -100, -1, -50,       10, 10, 10, 10,       4'b0000, 1, 1);
        drain("drain_modes");

        // Config write in the same cycle as an accept applies only to later beats.
        cfg(1, 0, 0, 127, 0);
        cfg_mult = 16'd2;
        cfg_we = 1'b1;
        send(10, -3, 50, 0,          10, -3, 50, 0,        4'b0000, 1, 1);
        cfg_we = 1'b0;
        send(10, -3, 50, 0,          20, -6, 100, 0,       4'b0000, 1, 1);
        drain("drain_cfg");

        // Backpressure: identity config, random out_ready.
        cfg(1, 0, 0, 127, 0);
        bp_on = 1'b1;
        for (int i = 0; i < 10; i++) begin
            int b;
            b = i * 7 - 30;
            send(b, b + 1, b + 2, b + 3, b, b + 1, b + 2, b + 3, 4'b0000, 0, 1);
        end
        drain("drain_bp");
        bp_on = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Reset with three beats in flight; none of them may emerge afterwards.
        send(11, 22, 33, 44,  0, 0, 0, 0, 4'b0000, 0, 0);
        send(55, 66, 77, 88,  0, 0, 0, 0, 4'b0000, 0, 0);
        send(9, 8, 7, 6,      0, 0, 0, 0, 4'b0000, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_out_data", {32'd0, out_data}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_busy_after", 64'(busy), 64'd0);

        // Default config after reset: mult=1, shift=0, zp=0, mode NONE.
        send(300, -300, 7, -1,       127, -128, 7, -1,     4'b0011, 1, 1);
        drain("drain_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
